sobel_stream_ctrl: RTL and testbench

//  Streaming sequencer around the sobel_3x3_gray kernel. Accepts a raster grayscale frame over valid/ready.
//  Two line buffers and a 3x3 shift window feed the kernel, which is instantiated inside this block.

---
 rtl/sobel_stream_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sobel_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: raster gray stream -> 3x3 Sobel gradient stream with sof/eol markers and zeroed borders.
// Latency: IMG_W+1 accepted pixels plus one cycle; optional SOBEL_THRESH_EN adds a binarising threshold.
// Backpressure: a producing step waits for a free output slot; in_ready drops while stalled and during flush.

// sobel_3x3_gray: |gx|+|gy| over a 3x3 neighbourhood, shifted right and saturated to 8 bits.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is captured.
module sobel_3x3_gray #(
  parameter int SOBEL_SHIFT = 2
) (
  input  logic [7:0] p00, p01, p02,
  input  logic [7:0] p10,      p12,
  input  logic [7:0] p20, p21, p22,
  output logic [7:0] mag
);
  logic signed [12:0] gx, gy, ax, ay;
  logic [13:0] sum, shifted;

  function automatic logic signed [12:0] sx(input logic [7:0] p);
    return $signed({5'b0, p});
  endfunction

  always_comb begin
    gx      = sx(p02) + (sx(p12) <<< 1) + sx(p22) - sx(p00) - (sx(p10) <<< 1) - sx(p20);
    gy      = sx(p20) + (sx(p21) <<< 1) + sx(p22) - sx(p00) - (sx(p01) <<< 1) - sx(p02);
    ax      = gx[12] ? -gx : gx;
    ay      = gy[12] ? -gy : gy;
    sum     = {1'b0, ax} + {1'b0, ay};
    shifted = sum >> SOBEL_SHIFT;
    mag     = (|shifted[13:8]) ? 8'hFF : shifted[7:0];
  end
endmodule

module sobel_stream_ctrl #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int SOBEL_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SOBEL_THRESH_EN
  input  logic [7:0] thresh,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  input  logic       in_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pixel,
  output logic       out_sof,
  output logic       out_eol,
  output logic       busy,
  output logic       sof_err
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int SW   = $clog2(NPIX + IMG_W + 1);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam logic [SW-1:0] PRIME     = SW'(IMG_W + 1);
  localparam logic [SW-1:0] LAST_IN   = SW'(NPIX - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(NPIX + IMG_W);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [SW-1:0] s_cnt;
  logic [CW-1:0] wr_col, wr_addr, out_col;
  logic [RW-1:0] out_row;
  logic          free, produce, step_ok, accept, flush_step, sof_start, step, load_out, border;
  logic [7:0]    step_pix, lb_top, lb_mid, kern_mag, interior;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    win_a [3];
  logic [7:0]    win_b [3];

  // Steps before the first output only need input; later steps also need the output slot.
  assign free       = !out_valid || out_ready;
  assign produce    = (state != IDLE) && (s_cnt >= PRIME);
  assign step_ok    = !produce || free;
  assign accept     = in_valid && in_ready;
  assign flush_step = (state == FLUSH) && free;
  assign sof_start  = accept && in_sof;
  assign step       = (accept && ((state != IDLE) || in_sof)) || flush_step;
  assign load_out   = step && produce && !sof_start;
  assign step_pix   = (state == FLUSH) ? 8'h00 : in_pixel;
  assign wr_addr    = sof_start ? '0 : wr_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sof_start) state_nxt = RUN;
      RUN:     if (accept && !in_sof && (s_cnt == LAST_IN)) state_nxt = FLUSH;
      FLUSH:   if (flush_step && (s_cnt == LAST_STEP)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    if (rst_n && (state != FLUSH)) in_ready = step_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt   <= '0;
      wr_col  <= '0;
      out_row <= '0;
      out_col <= '0;
      sof_err <= 1'b0;
    end else begin
      if (step) begin
        if (sof_start)               s_cnt <= SW'(1);
        else if (s_cnt == LAST_STEP) s_cnt <= '0;
        else                         s_cnt <= s_cnt + 1'b1;
        wr_col <= (wr_addr == COL_MAX) ? '0 : wr_addr + 1'b1;
      end
      if (sof_start) begin
        out_row <= '0;
        out_col <= '0;
      end else if (load_out) begin
        if (out_col == COL_MAX) begin
          out_col <= '0;
          out_row <= (out_row == ROW_MAX) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      if (sof_start && (state == RUN)) sof_err <= 1'b1;
    end
  end

  // Line buffers and window carry no reset; stale taps only ever reach border outputs.
  assign lb_top = lb1[wr_addr];
  assign lb_mid = lb0[wr_addr];

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[wr_addr] <= step_pix;
      lb1[wr_addr] <= lb_mid;
      win_a        <= win_b;
      win_b[0]     <= lb_top;
      win_b[1]     <= lb_mid;
      win_b[2]     <= step_pix;
    end
  end

  // The incoming column is the window's right edge, so the result is ready on the step edge.
  sobel_3x3_gray #(.SOBEL_SHIFT(SOBEL_SHIFT)) u_kernel (
    .p00(win_a[0]), .p01(win_b[0]), .p02(lb_top),
    .p10(win_a[1]),                 .p12(lb_mid),
    .p20(win_a[2]), .p21(win_b[2]), .p22(step_pix),
    .mag(kern_mag)
  );

`ifdef SOBEL_THRESH_EN
  assign interior = (kern_mag >= thresh) ? 8'hFF : 8'h00;
`else
  assign interior = kern_mag;
`endif

  assign border = (out_row == '0) || (out_row == ROW_MAX) || (out_col == '0) || (out_col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= 8'h00;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_pixel <= border ? 8'h00 : interior;
      out_sof   <= (out_row == '0) && (out_col == '0);
      out_eol   <= (out_col == COL_MAX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Bench for sobel_stream_ctrl at 8x6: frame-level reference model plus directed frames and literal pins.
module tb_sobel_stream_ctrl;
  localparam int W = 8, H = 6, SH = 2, NPIX = W * H;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [7:0] in_pixel = 8'h00;
  logic       in_ready, out_valid, out_sof, out_eol, busy, sof_err;
  logic [7:0] out_pixel;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = 8'h40;
`endif

  int         n_total = 0, n_bad = 0;
  logic [9:0] expq[$];
  int         fr[NPIX];
  int         n_px = 0;
  bit         in_frame = 0;
  logic       exp_sof_err = 1'b0;
  logic       hold_vld = 1'b0;
  logic [9:0] hold_dat = '0;
  logic [7:0] got[1024];
  int         cnt_out = 0, cnt_sof = 0, cnt_eol = 0, cnt_nz = 0;
  bit         toggle_en = 0;

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .SOBEL_SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SOBEL_THRESH_EN
    .thresh(thresh),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int px(int r, int c);
    return fr[r * W + c];
  endfunction

  function automatic logic [7:0] exp_pix(int j);
    int r, c, gx, gy, m;
    r = j / W;
    c = j % W;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'h00;
    gx = px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1) - px(r-1, c-1) - 2 * px(r, c-1) - px(r+1, c-1);
    gy = px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1) - px(r-1, c-1) - 2 * px(r-1, c) - px(r-1, c+1);
    m = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> SH;
    if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
    return (m >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(m);
`endif
  endfunction

  task automatic push_exp(int j);
    expq.push_back({exp_pix(j), (j == 0), (j % W == W - 1)});
  endtask

  // Output j is known once pixel j+W+1 has arrived; the remaining W+1 follow the frame's last pixel.
  task automatic model_accept(input logic [7:0] p, input logic s);
    if (s) begin
      if (in_frame) exp_sof_err = 1'b1;
      in_frame = 1;
      n_px = 0;
    end else if (!in_frame) begin
      return;
    end
    fr[n_px] = int'(p);
    n_px++;
    if (n_px - 1 >= W + 1) push_exp(n_px - 1 - (W + 1));
    if (n_px == NPIX) begin
      for (int j = NPIX - W - 1; j < NPIX; j++) push_exp(j);
      in_frame = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      in_frame = 0;
      n_px = 0;
      exp_sof_err = 1'b0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) check("stall_hold", {out_valid, out_pixel, out_sof, out_eol}, {1'b1, hold_dat});
      if (out_valid && out_ready) begin
        check("out_expected", expq.size() != 0, 1);
        if (expq.size() != 0) check("out_dat", {out_pixel, out_sof, out_eol}, expq.pop_front());
        got[cnt_out] = out_pixel;
        cnt_out++;
        cnt_sof += int'(out_sof);
        cnt_eol += int'(out_eol);
        if (out_pixel != 8'h00) cnt_nz++;
      end
      hold_vld = out_valid && !out_ready;
      hold_dat = {out_pixel, out_sof, out_eol};
      check("sof_err", sof_err, exp_sof_err);
      if (in_valid && in_ready) model_accept(in_pixel, in_sof);
    end
  end

  function automatic logic [7:0] pat(int kind, int i);
    case (kind)
      0:       return 8'h80;
      1:       return ((i % W) >= 4) ? 8'hFF : 8'h00;
      default: return 8'((i * 37 + (i >> 1) * 91) & 255);
    endcase
  endfunction

  task automatic send(input logic [7:0] p, input logic s);
    logic took;
    int   guard;
    took = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof = s;
    while (!took && guard < 400) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    check("accept", took, 1);
  endtask

  task automatic send_range(input int kind, input int from, input int to);
    for (int i = from; i <= to; i++) send(pat(kind, i), i == 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((expq.size() != 0 || out_valid || busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("drain", (expq.size() == 0) && !out_valid && !busy, 1);
  endtask

  task automatic check_step(input int b, input int nz0);
    check("step_r1c3", got[b + 11], 8'hFF);
    check("step_r1c4", got[b + 12], 8'hFF);
    check("step_r1c2", got[b + 10], 8'h00);
    check("step_r1c5", got[b + 13], 8'h00);
    check("step_r3c4", got[b + 28], 8'hFF);
    check("step_r4c3", got[b + 35], 8'hFF);
    check("step_r0c4", got[b + 4],  8'h00);
    check("step_r5c3", got[b + 43], 8'h00);
    check("step_count", cnt_out - b, NPIX);
    check("step_nonzero", cnt_nz - nz0, 8);
  endtask

  initial begin
    int b, s0, e0, nz0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_sof_err", sof_err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pixels without sof while idle are swallowed.
    b = cnt_out;
    for (int i = 0; i < 3; i++) send(8'h55, 1'b0);
    check("idle_drop_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("idle_drop_out", cnt_out - b, 0);

    // Flat frame with latency and flush pins.
    b = cnt_out; s0 = cnt_sof; e0 = cnt_eol; nz0 = cnt_nz;
    for (int i = 0; i < NPIX; i++) begin
      send(pat(0, i), i == 0);
      if (i == 0) check("busy_run", busy, 1);
      if (i == W) check("lat_before_first", out_valid, 0);
      if (i == W + 1) check("lat_first_valid", out_valid, 1);
      if (i == W + 1) check("lat_first_sof", out_sof, 1);
    end
    check("flush_busy", busy, 1);
    check("flush_in_ready", in_ready, 0);
    drain();
    check("flat_count", cnt_out - b, NPIX);
    check("flat_sof", cnt_sof - s0, 1);
    check("flat_eol", cnt_eol - e0, H);
    check("flat_nonzero", cnt_nz - nz0, 0);

    b = cnt_out; nz0 = cnt_nz;
    send_range(1, 0, NPIX - 1);
    drain();
    check_step(b, nz0);

    toggle_en = 1;
    b = cnt_out; nz0 = cnt_nz;
    send_range(1, 0, NPIX - 1);
    drain();
    check_step(b, nz0);

    // Ramp frame, then a frame that starts during flush and is restarted by sof at k=20.
    b = cnt_out; s0 = cnt_sof; e0 = cnt_eol;
    send_range(2, 0, NPIX - 1);
    send_range(1, 0, 19);
    send_range(2, 0, NPIX - 1);
    drain();
    check("restart_sof_err", sof_err, 1);
    check("restart_count", cnt_out - b, NPIX + 11 + NPIX);
    check("restart_sof", cnt_sof - s0, 3);
    toggle_en = 0;

    send_range(2, 0, 29);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_pixel", out_pixel, 0);
    check("midrst_out_sof", out_sof, 0);
    check("midrst_out_eol", out_eol, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sof_err", sof_err, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    b = cnt_out; nz0 = cnt_nz;
    send_range(1, 0, NPIX - 1);
    drain();
    check_step(b, nz0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
